// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and frame-address helper for the tile reader.
// Used by both builds of fb_tile_reader (FB_TILE_COUNT_EN defined or undefined).
package fb_pkg;

  localparam int unsigned DEF_WIDTH     = 160;
  localparam int unsigned DEF_HEIGHT    = 120;
  localparam logic [2:0]  DEF_BG_COLOUR = 3'b111;
  localparam int unsigned TILE_SIZE     = 4;
  localparam int unsigned TILE_PIXELS   = TILE_SIZE * TILE_SIZE;
  localparam int unsigned ADDR_W        = 15;
  localparam int unsigned COLOUR_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } fb_state_t;

  // Row-major frame address; callers guarantee x < width and y < screen height.
  function automatic logic [ADDR_W-1:0] addr(input logic [7:0] x, input logic [6:0] y,
                                             input int unsigned width);
    return ADDR_W'(32'(y) * width + 32'(x));
  endfunction

endpackage

// File: rtl/fb_shadow_ram.sv
// Single-port shadow frame RAM: registered read, write-first on the shared address.
module fb_shadow_ram
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_WIDTH * DEF_HEIGHT
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [COLOUR_W-1:0] i_wdata,
  output logic [COLOUR_W-1:0] o_rdata
);

  logic [COLOUR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      o_rdata       <= i_wdata;
    end else begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/fb_tile_reader.sv
// Mirrors sprite plots into a shadow frame and answers 4x4 tile collision queries.
// Build option FB_TILE_COUNT_EN: adds q_count and forces full 16-pixel scans.
module fb_tile_reader
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned HEIGHT    = DEF_HEIGHT,
  parameter logic [2:0]  BG_COLOUR = DEF_BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] c_in,
  input  logic       plot_en,
  input  logic       q_start,
  input  logic [7:0] q_x,
  input  logic [6:0] q_y,
  output logic       q_busy,
  output logic       q_done,
  output logic       q_hit,
  output logic [2:0] q_colour
`ifdef FB_TILE_COUNT_EN
  ,
  output logic [4:0] q_count
`endif
);

  localparam logic [3:0] LAST_OFF = 4'(TILE_PIXELS - 1);

  fb_state_t   r_state;
  logic [7:0]  r_qx;
  logic [6:0]  r_qy;
  logic [3:0]  r_off;
  logic        r_rd_valid;
  logic        r_rd_onscr;

  logic [8:0]        w_px;
  logic [7:0]        w_py;
  logic              w_onscr;
  logic              w_plot_we;
  logic              w_issue;
  logic              w_evaluating;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [2:0]        w_rdata;
  logic [2:0]        w_eval;
  logic              w_eval_hit;

  // Tile pixel for the current offset, kept wide so edge tiles do not wrap.
  assign w_px    = 9'(r_qx) + 9'(r_off[1:0]);
  assign w_py    = 8'(r_qy) + 8'(r_off[3:2]);
  assign w_onscr = (32'(w_px) < WIDTH) && (32'(w_py) < HEIGHT);

  // Plotting owns the single RAM port; any plot during SCAN stalls the issue.
  assign w_plot_we = plot_en && (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
  assign w_issue   = (r_state == SCAN) && !plot_en;

  assign w_ram_addr = w_plot_we ? addr(x_in, y_in, WIDTH)
                    : (w_onscr ? addr(w_px[7:0], w_py[6:0], WIDTH) : '0);

  fb_shadow_ram #(
    .DEPTH (WIDTH * HEIGHT)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_plot_we),
    .i_addr  (w_ram_addr),
    .i_wdata (c_in),
    .o_rdata (w_rdata)
  );

  // Off-screen offsets were never read and evaluate as background.
  assign w_evaluating = (r_state == SCAN) || (r_state == DRAIN);
  assign w_eval       = r_rd_onscr ? w_rdata : BG_COLOUR;
  assign w_eval_hit   = w_evaluating && r_rd_valid && (w_eval != BG_COLOUR);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_qx       <= '0;
      r_qy       <= '0;
      r_off      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_onscr <= 1'b0;
      q_busy     <= 1'b0;
      q_done     <= 1'b0;
      q_hit      <= 1'b0;
      q_colour   <= BG_COLOUR;
`ifdef FB_TILE_COUNT_EN
      q_count    <= '0;
`endif
    end else begin
      q_done     <= 1'b0;
      r_rd_valid <= w_issue;
      r_rd_onscr <= w_onscr;

      if (w_eval_hit) begin
        if (!q_hit) q_colour <= w_eval;
        q_hit <= 1'b1;
`ifdef FB_TILE_COUNT_EN
        q_count <= q_count + 5'd1;
`endif
      end

      case (r_state)
        IDLE: begin
          if (q_start) begin
            r_qx     <= q_x;
            r_qy     <= q_y;
            r_off    <= '0;
            q_hit    <= 1'b0;
            q_colour <= BG_COLOUR;
`ifdef FB_TILE_COUNT_EN
            q_count  <= '0;
`endif
            q_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (w_issue) r_off <= r_off + 4'd1;
`ifndef FB_TILE_COUNT_EN
          if (w_eval_hit) begin
            q_busy  <= 1'b0;
            q_done  <= 1'b1;
            r_state <= DONE;
          end else
`endif
          if (w_issue && (r_off == LAST_OFF)) r_state <= DRAIN;
        end
        DRAIN: begin
          q_busy  <= 1'b0;
          q_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
